// File: rtl/hilo_div_unit_if.sv
// HI/LO register and divider port bundle: pipeline-side requests and the
// unit's register/status outputs.
interface hilo_div_unit_if;
  logic        write_en;
  logic [63:0] alu_result2;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        div_done;
  logic        div_by_zero;

  modport master (
    output write_en, alu_result2, div_start, div_signed, div_a, div_b,
    input  hi, lo, busy, div_done, div_by_zero
  );

  modport slave (
    input  write_en, alu_result2, div_start, div_signed, div_a, div_b,
    output hi, lo, busy, div_done, div_by_zero
  );
endinterface

// File: rtl/hilo_div_unit.sv
// HI/LO register pair with a 33-cycle restoring divider (DIV/DIVU).
// state  | meaning
// IDLE   | HI/LO writable from the ALU, waiting for a divide request
// RUN    | 32 restoring steps, one quotient bit per edge, MSB first
// FINISH | sign-fix the result and commit it to HI/LO
module hilo_div_unit (
  input  logic           clk,
  input  logic           reset,
  hilo_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] rq;
  logic [31:0] divisor;
  logic [31:0] raw_a;
  logic [31:0] hi_q, lo_q;
  logic        q_neg, r_neg, by_zero;
  logic        done_q, dbz_q;
  logic [32:0] trial;
  logic [31:0] quo_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.div_start) state_nxt = RUN;
      RUN:     if (cnt == 5'd31) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Remainder is always below the divisor, so the borrow bit alone decides the step.
  assign trial   = rq[63:31] - {1'b0, divisor};
  assign quo_fix = q_neg ? (32'd0 - rq[31:0])  : rq[31:0];
  assign rem_fix = r_neg ? (32'd0 - rq[63:32]) : rq[63:32];

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      cnt     <= '0;
      rq      <= '0;
      divisor <= '0;
      raw_a   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      by_zero <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.write_en) begin
            hi_q <= bus.alu_result2[63:32];
            lo_q <= bus.alu_result2[31:0];
          end
          if (bus.div_start) begin
            rq      <= {32'd0, (bus.div_signed && bus.div_a[31]) ? (32'd0 - bus.div_a) : bus.div_a};
            divisor <= (bus.div_signed && bus.div_b[31]) ? (32'd0 - bus.div_b) : bus.div_b;
            q_neg   <= bus.div_signed & (bus.div_a[31] ^ bus.div_b[31]);
            r_neg   <= bus.div_signed & bus.div_a[31];
            by_zero <= (bus.div_b == 32'd0);
            raw_a   <= bus.div_a;
            cnt     <= '0;
          end
        end
        RUN: begin
          rq  <= trial[32] ? {rq[62:0], 1'b0} : {trial[31:0], rq[30:0], 1'b1};
          cnt <= cnt + 5'd1;
        end
        FINISH: begin
          hi_q   <= by_zero ? raw_a : rem_fix;
          lo_q   <= by_zero ? 32'hFFFF_FFFF : quo_fix;
          done_q <= 1'b1;
          dbz_q  <= by_zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state != IDLE);
  assign bus.div_done    = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/hilo_div_unit.md
HILO_DIV_UNIT -- requirements
Module: hilo_div_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state changes occur on the rising edge of Clk.
REQ-002 Port: Clk  input  1  system clock.
REQ-003 Port: Reset  input  1  synchronous active-high reset.
REQ-004 Port: WriteEn  input  1  commit ALUResult2In into HI/LO (MULT, MULTU, MADD, MSUB, MTHI, MTLO).
REQ-005 Port: ALUResult2In  input  64  {HI, LO} value produced by the ALU.
REQ-006 Port: DivStart  input  1  one-cycle request to begin DIV/DIVU.
REQ-007 Port: DivSigned  input  1  1 = DIV (signed), 0 = DIVU; sampled with DivStart.
REQ-008 Port: DivA  input  32  dividend (rs); sampled with DivStart.
REQ-009 Port: DivB  input  32  divisor (rt); sampled with DivStart.
REQ-010 Port: HiOut  output  32  current HI register; drives the ALU ALUhi input.
REQ-011 Port: LoOut  output  32  current LO register; drives the ALU ALUlo input.
REQ-012 Port: Busy  output  1  high while a division is in progress; the pipeline stalls on it.
REQ-013 Port: DivDone  output  1  one-cycle pulse; division result is visible on HiOut/LoOut.
REQ-014 Port: DivByZero  output  1  one-cycle pulse coincident with DivDone when DivB was 0.

Function
REQ-015 The state machine SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-016 IDLE with DivStart=1 at edge E0: latch |DivA|, |DivB| (magnitudes only when DivSigned=1), the result signs and the raw DivA; clear the 5-bit counter; go to RUN; Busy=1 from the cycle after E0.
REQ-017 RUN: restoring division, one quotient bit per edge, MSB first; 64-bit {remainder, quotient} shift register; 33-bit trial subtraction.
REQ-018 RUN SHALL last exactly 32 edges (E1..E32, counter 0..31); on counter=31 go to FINISH.
REQ-019 FINISH at edge E33: write LO=quotient and HI=remainder; DivDone=1 and Busy=0 in the cycle after E33; return to IDLE.
REQ-020 Total latency: DivStart sampled at E0 -> DivDone and the new HI/LO visible after E33 (33 cycles).
REQ-021 Signed sign rules: quotient negated when the operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000 (no trap).
REQ-023 DivB=0: the full 33-cycle latency still applies; result LO=0xFFFFFFFF, HI=raw DivA; DivByZero pulses with DivDone.
REQ-024 WriteEn=1 while not Busy: at the next edge HI<=ALUResult2In[63:32] and LO<=ALUResult2In[31:0].
REQ-025 WriteEn while Busy (RUN or FINISH) SHALL be ignored; the division owns HI/LO.
REQ-026 DivStart while Busy SHALL be ignored; the running division is not restarted.
REQ-027 WriteEn and DivStart in the same IDLE cycle: the WriteEn value is written at E0 and the division starts; the division result later overwrites HI/LO at E33.
REQ-028 HiOut/LoOut SHALL come directly from registers, with no combinational path from any input.
REQ-029 DivDone and DivByZero SHALL be registered and last exactly one cycle.

Reset
REQ-030 Reset=1 at an edge SHALL force: HI=0, LO=0, state=IDLE, counter=0, Busy=0, DivDone=0, DivByZero=0.
REQ-031 Reset during RUN or FINISH SHALL abort the division with no HI/LO write and no DivDone pulse.
REQ-032 Reset SHALL take priority over WriteEn and DivStart in the same cycle.

Verification
REQ-033 DIVU 100/7, DivStart at E0 -> Busy high for E1..E33; after E33 LO=0x0000000E, HI=0x00000002, DivDone pulse for 1 cycle.
REQ-034 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 DIVU 0x12345678/0 -> after 33 cycles LO=0xFFFFFFFF, HI=0x12345678; DivByZero and DivDone high for the same single cycle.
REQ-036 WriteEn with ALUResult2In=0x00000001_00000002 in IDLE -> next cycle HiOut=1, LoOut=2; the same WriteEn pulsed at cycle 5 of a division -> no effect on the final result.
REQ-037 Reset asserted at RUN cycle 10 of a division, with HI/LO preloaded 0xAAAA/0x5555 -> next cycle HI=LO=0, Busy=0, and no DivDone ever appears.
REQ-038 DivStart re-pulsed at cycle 20 of a division -> ignored; completion still occurs after E33 with the first operands' result.
